// File: rtl/cnn_layer_accel_prefetch_rd_seq.sv
// Read-side sequencer for the per-row prefetch buffer: walks rows/cols, requests row fetches,
// issues credit-limited buffer reads and streams captured pixels through a small skid FIFO.
module cnn_layer_accel_prefetch_rd_seq #(
  parameter int unsigned C_COL_WIDTH   = 10,
  parameter int unsigned C_PIXEL_WIDTH = 16,
  parameter int unsigned C_RD_LATENCY  = 2,
  parameter int unsigned C_OBUF_DEPTH  = 4
) (
  input  logic                     rd_clk,
  input  logic                     rst,
  input  logic                     job_start,
  input  logic [C_COL_WIDTH-1:0]   num_cols,
  input  logic [C_COL_WIDTH-1:0]   num_rows,
  output logic                     fetch_req,
  input  logic                     row_ready,
  input  logic                     cncl_fetch_req,
  output logic                     rd_en,
  output logic [C_COL_WIDTH-1:0]   input_col,
  output logic [C_COL_WIDTH-1:0]   input_row,
  output logic                     next_row,
  output logic                     rst_addr,
  input  logic [C_PIXEL_WIDTH-1:0] pix_in,
  output logic                     pix_valid,
  output logic [C_PIXEL_WIDTH-1:0] pix_data,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     job_done
);

  localparam int unsigned PW = (C_OBUF_DEPTH > 1) ? $clog2(C_OBUF_DEPTH) : 1;
  localparam int unsigned NW = $clog2(C_OBUF_DEPTH + 1);
  localparam int unsigned KW = $clog2(C_OBUF_DEPTH + C_RD_LATENCY + 2);

  typedef enum logic [2:0] {S_IDLE, S_ROW_CHK, S_FETCH, S_ROW_RD, S_ROW_END, S_DRAIN} state_t;

  state_t                   state_q;
  logic [C_COL_WIDTH-1:0]   cols_q, rows_q, input_col_q, input_row_q;
  logic                     rd_en_q, fetch_req_q, next_row_q, rst_addr_q, busy_q, job_done_q;
  logic [C_RD_LATENCY-1:0]  vld_q;
  logic [C_PIXEL_WIDTH-1:0] mem_q [C_OBUF_DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]            cnt_q, cnt_d;
  logic [KW-1:0]            inflight, committed;
  logic                     push, pop, credit, last_col, last_row, drained;

  assign pix_valid = (cnt_q != '0);
  assign pix_data  = pix_valid ? mem_q[rd_ptr_q] : '0;
  assign fetch_req = fetch_req_q;
  assign rd_en     = rd_en_q;
  assign input_col = input_col_q;
  assign input_row = input_row_q;
  assign next_row  = next_row_q;
  assign rst_addr  = rst_addr_q;
  assign busy      = busy_q;
  assign job_done  = job_done_q;

  // Credit counts everything already committed to land in the FIFO, net of this cycle's pop
  always_comb begin
    push     = vld_q[C_RD_LATENCY-1];
    pop      = pix_valid & pix_ready;
    inflight = '0;
    for (int unsigned i = 0; i < C_RD_LATENCY; i++) begin
      inflight = inflight + KW'(vld_q[i]);
    end
    committed = KW'(cnt_q) + inflight + KW'(rd_en_q) - KW'(pop);
    credit    = committed < KW'(C_OBUF_DEPTH);
    cnt_d     = cnt_q + NW'(push) - NW'(pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(C_OBUF_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(C_OBUF_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    last_col = (input_col_q == cols_q - C_COL_WIDTH'(1));
    last_row = (input_row_q == rows_q - C_COL_WIDTH'(1));
    drained  = (vld_q == '0) && ((cnt_q == '0) || ((cnt_q == NW'(1)) && pop));
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      input_col_q <= '0;
      input_row_q <= '0;
      rd_en_q     <= 1'b0;
      fetch_req_q <= 1'b0;
      next_row_q  <= 1'b0;
      rst_addr_q  <= 1'b0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      job_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (job_start) begin
            cols_q      <= num_cols;
            rows_q      <= num_rows;
            input_col_q <= '0;
            input_row_q <= '0;
            if ((num_cols == '0) || (num_rows == '0)) begin
              job_done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_ROW_CHK;
            end
          end
        end
        S_ROW_CHK: begin
          if (cncl_fetch_req) begin
            rd_en_q <= credit;
            state_q <= S_ROW_RD;
          end else begin
            fetch_req_q <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (row_ready) begin
            fetch_req_q <= 1'b0;
            rd_en_q     <= credit;
            state_q     <= S_ROW_RD;
          end
        end
        S_ROW_RD: begin
          if (rd_en_q && last_col) begin
            rd_en_q     <= 1'b0;
            input_col_q <= '0;
            next_row_q  <= 1'b1;
            rst_addr_q  <= 1'b1;
            state_q     <= S_ROW_END;
          end else begin
            if (rd_en_q) input_col_q <= input_col_q + C_COL_WIDTH'(1);
            rd_en_q <= credit;
          end
        end
        S_ROW_END: begin
          next_row_q <= 1'b0;
          rst_addr_q <= 1'b0;
          if (last_row) begin
            state_q <= S_DRAIN;
          end else begin
            input_row_q <= input_row_q + C_COL_WIDTH'(1);
            state_q     <= S_ROW_CHK;
          end
        end
        S_DRAIN: begin
          if (drained) begin
            job_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read-latency valid pipe and skid FIFO bookkeeping
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      vld_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q[0] <= rd_en_q;
      for (int unsigned i = 1; i < C_RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_in;
  end

endmodule

// File: tb/tb_cnn_layer_accel_prefetch_rd_seq.sv
// Directed bench for the prefetch read sequencer: models the row buffer (latency, padding,
// repeat rows), runs a job table and hand-written stall/reset/zero-dim sequences.
module tb_cnn_layer_accel_prefetch_rd_seq;

  localparam int unsigned CW    = 10;
  localparam int unsigned PXW   = 16;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic rd_clk = 1'b0;
  logic rst, job_start, row_ready, cncl_fetch_req, pix_ready;
  logic [CW-1:0] num_cols, num_rows, input_col, input_row;
  logic fetch_req, rd_en, next_row, rst_addr, pix_valid, busy, job_done;
  logic [PXW-1:0] pix_in, pix_data;

  always #5 rd_clk = ~rd_clk;

  cnn_layer_accel_prefetch_rd_seq #(
    .C_COL_WIDTH(CW), .C_PIXEL_WIDTH(PXW), .C_RD_LATENCY(LAT), .C_OBUF_DEPTH(DEPTH)
  ) dut (
    .rd_clk(rd_clk), .rst(rst), .job_start(job_start), .num_cols(num_cols), .num_rows(num_rows),
    .fetch_req(fetch_req), .row_ready(row_ready), .cncl_fetch_req(cncl_fetch_req),
    .rd_en(rd_en), .input_col(input_col), .input_row(input_row), .next_row(next_row),
    .rst_addr(rst_addr), .pix_in(pix_in), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy), .job_done(job_done)
  );

  typedef struct {
    int          cols;
    int          rows;
    logic [15:0] cncl;
    logic [15:0] pad;
    int          e_fetch;
    int          e_rd;
    int          e_pix;
    int          e_nrow;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt, fetch_cnt, nr_cnt, ra_cnt, jd_cnt, acc_cnt;
  logic fr_prev = 1'b0;
  logic hold_v = 1'b0;
  logic [PXW-1:0] hold_d;
  logic [PXW-1:0] exp_q[$];
  logic cncl_tbl[16];
  logic pad_tbl[16];
  int buf_row = 0;
  int fr_cnt = 0;
  logic [PXW-1:0] h_d[LAT];

  function automatic logic [PXW-1:0] pixf(input int r, input int c);
    logic [PXW-1:0] v;
    v = 16'hA000;
    v[11:8] = r[3:0];
    v[7:0]  = c[7:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Row buffer model: read data appears LAT cycles after rd_en; padding rows read as zero
  always @(posedge rd_clk) begin
    h_d[0] <= pad_tbl[input_row[3:0]] ? '0 : pixf(buf_row, int'(input_col));
    for (int i = 1; i < LAT; i++) h_d[i] <= h_d[i-1];
  end
  assign pix_in = h_d[LAT-1];

  // Buffer control responder: cancel lookup and row_ready 3 cycles into a fetch
  always @(posedge rd_clk) begin
    #1;
    cncl_fetch_req = cncl_tbl[input_row[3:0]];
    if (fetch_req) begin
      fr_cnt++;
      if (fr_cnt == 3) begin
        row_ready = 1'b1;
        buf_row   = int'(input_row);
      end else begin
        row_ready = 1'b0;
      end
    end else begin
      fr_cnt    = 0;
      row_ready = 1'b0;
    end
  end

  // Output monitor: event counters, in-order data check, hold check under backpressure
  always @(negedge rd_clk) begin
    if (!rst) begin
      if (rd_en) rd_cnt++;
      if (fetch_req && !fr_prev) fetch_cnt++;
      fr_prev = fetch_req;
      if (next_row) nr_cnt++;
      if (rst_addr) ra_cnt++;
      if (job_done) jd_cnt++;
      if (hold_v) begin
        chk("pix_hold_valid", int'(pix_valid), 1);
        chk("pix_hold_data", int'(pix_data), int'(hold_d));
      end
      hold_v = pix_valid && !pix_ready;
      hold_d = pix_data;
      if (pix_valid && pix_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("pix_unexpected", int'(pix_data), -1);
        else chk("pix_data", int'(pix_data), int'(exp_q.pop_front()));
      end
    end else begin
      hold_v  = 1'b0;
      fr_prev = 1'b0;
    end
  end

  task automatic clr_counts();
    rd_cnt = 0; fetch_cnt = 0; nr_cnt = 0; ra_cnt = 0; jd_cnt = 0; acc_cnt = 0;
  endtask

  task automatic start_vec(input vec_t v);
    int src;
    for (int i = 0; i < 16; i++) begin
      cncl_tbl[i] = v.cncl[i];
      pad_tbl[i]  = v.pad[i];
    end
    exp_q.delete();
    src = 0;
    for (int r = 0; r < v.rows; r++) begin
      if (!v.cncl[r]) src = r;
      for (int c = 0; c < v.cols; c++) exp_q.push_back(v.pad[r] ? '0 : pixf(src, c));
    end
    clr_counts();
    num_cols  = CW'(v.cols);
    num_rows  = CW'(v.rows);
    job_start = 1'b1;
    @(posedge rd_clk); #1;
    job_start = 1'b0;
  endtask

  task automatic finish_vec(input vec_t v, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge rd_clk); #1;
      if (jd_cnt > 0) ok = 1'b1;
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
    repeat (3) @(posedge rd_clk);
    #1;
    chk({tag, "_job_done"}, jd_cnt, 1);
    chk({tag, "_fetches"}, fetch_cnt, v.e_fetch);
    chk({tag, "_rd_en"}, rd_cnt, v.e_rd);
    chk({tag, "_pixels"}, acc_cnt, v.e_pix);
    chk({tag, "_next_row"}, nr_cnt, v.e_nrow);
    chk({tag, "_rst_addr"}, ra_cnt, v.e_nrow);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t vstall, vrst;
    bit seen;
    int rd0, fe0;

    vecs[0] = '{cols: 4, rows: 2, cncl: 16'h0000, pad: 16'h0000, e_fetch: 2, e_rd: 8,  e_pix: 8,  e_nrow: 2};
    vecs[1] = '{cols: 4, rows: 3, cncl: 16'h0005, pad: 16'h0005, e_fetch: 1, e_rd: 12, e_pix: 12, e_nrow: 3};
    vecs[2] = '{cols: 8, rows: 4, cncl: 16'h000A, pad: 16'h0000, e_fetch: 2, e_rd: 32, e_pix: 32, e_nrow: 4};
    vecs[3] = '{cols: 1, rows: 3, cncl: 16'h0000, pad: 16'h0000, e_fetch: 3, e_rd: 3,  e_pix: 3,  e_nrow: 3};
    vstall  = '{cols: 16, rows: 1, cncl: 16'h0000, pad: 16'h0000, e_fetch: 1, e_rd: 16, e_pix: 16, e_nrow: 1};
    vrst    = '{cols: 8, rows: 2, cncl: 16'h0000, pad: 16'h0000, e_fetch: 2, e_rd: 16, e_pix: 16, e_nrow: 2};

    for (int i = 0; i < 16; i++) begin
      cncl_tbl[i] = 1'b0;
      pad_tbl[i]  = 1'b0;
    end
    clr_counts();
    rst = 1'b1; job_start = 1'b0; num_cols = '0; num_rows = '0;
    row_ready = 1'b0; cncl_fetch_req = 1'b0; pix_ready = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1;
    chk("rst_ctl", int'({fetch_req, rd_en, next_row, rst_addr, pix_valid, busy, job_done}), 0);
    chk("rst_col", int'(input_col), 0);
    chk("rst_row", int'(input_row), 0);
    chk("rst_pix", int'(pix_data), 0);
    rst = 1'b0;
    @(posedge rd_clk); #1;

    for (int i = 0; i < 4; i++) begin
      start_vec(vecs[i]);
      finish_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // job_start while busy with different dims must be ignored
    start_vec(vecs[0]);
    repeat (4) @(posedge rd_clk);
    #1;
    chk("busy_during_job", int'(busy), 1);
    num_cols = CW'(2); num_rows = CW'(1); job_start = 1'b1;
    @(posedge rd_clk); #1;
    job_start = 1'b0;
    finish_vec(vecs[0], "busy_ignore");

    // Downstream stall mid-row: reads stop with DEPTH outstanding, data held
    start_vec(vstall);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge rd_clk); #1;
      if (acc_cnt >= 3) seen = 1'b1;
    end
    if (!seen) chk("stall_start_timeout", 0, 1);
    pix_ready = 1'b0;
    repeat (10) @(posedge rd_clk);
    #1;
    chk("stall_rd_en", int'(rd_en), 0);
    chk("stall_valid", int'(pix_valid), 1);
    chk("stall_outstanding", rd_cnt - acc_cnt, int'(DEPTH));
    pix_ready = 1'b1;
    finish_vec(vstall, "stall");

    // Reset in the middle of ROW_RD aborts the job
    start_vec(vrst);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge rd_clk); #1;
      if (rd_en && input_col == CW'(3)) seen = 1'b1;
    end
    if (!seen) chk("midrst_timeout", 0, 1);
    rst = 1'b1;
    @(posedge rd_clk); #1;
    chk("midrst_ctl", int'({fetch_req, rd_en, next_row, rst_addr, pix_valid, busy, job_done}), 0);
    chk("midrst_col", int'(input_col), 0);
    chk("midrst_row", int'(input_row), 0);
    rst = 1'b0;
    repeat (8) @(posedge rd_clk);
    #1;
    chk("midrst_no_done", jd_cnt, 0);
    chk("midrst_idle_busy", int'(busy), 0);
    start_vec(vecs[0]);
    finish_vec(vecs[0], "after_rst");

    // Zero-dimension jobs complete at once with no activity
    for (int k = 0; k < 2; k++) begin
      rd0 = rd_cnt; fe0 = fetch_cnt;
      num_cols = (k == 0) ? CW'(0) : CW'(5);
      num_rows = (k == 0) ? CW'(3) : CW'(0);
      job_start = 1'b1;
      @(posedge rd_clk); #1;
      job_start = 1'b0;
      chk($sformatf("zero%0d_job_done", k), int'(job_done), 1);
      chk($sformatf("zero%0d_busy", k), int'(busy), 0);
      @(posedge rd_clk); #1;
      chk($sformatf("zero%0d_done_pulse", k), int'(job_done), 0);
      repeat (3) @(posedge rd_clk);
      #1;
      chk($sformatf("zero%0d_rd_en", k), rd_cnt - rd0, 0);
      chk($sformatf("zero%0d_fetch", k), fetch_cnt - fe0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
